eve_gene_aligner: RTL

Upstream feeder for the EvE crossover array. Takes two parent genomes as gene streams, each sorted ascending by innovation key, and merge-joins them. It issues one aligned gene pair per transfer on `parent1`/`parent2` with `wr_en`, in exactly the form EvE consumes. Matching genes are paired. Disjoint and excess genes are kept or dropped according to relative parent fitness.

---
 rtl/eve_gene_aligner.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/eve_gene_aligner.sv
// eve_gene_aligner: merge-joins two innovation-sorted parent genomes
// into aligned gene pairs for the EvE crossover array.
module eve_gene_aligner #(
  parameter int GENE_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        fit_sel,
  input  logic [GENE_W-1:0] a_gene,
  input  logic              a_valid,
  input  logic              a_last,
  output logic              a_ready,
  input  logic [GENE_W-1:0] b_gene,
  input  logic              b_valid,
  input  logic              b_last,
  output logic              b_ready,
  output logic [GENE_W-1:0] parent1,
  output logic [GENE_W-1:0] parent2,
  output logic              wr_en,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  disjoint_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_fit;
  logic [GENE_W-1:0] r_p1;
  logic [GENE_W-1:0] r_p2;
  logic              r_wr;
  logic              r_done;
  logic [CNT_W-1:0]  r_match;
  logic [CNT_W-1:0]  r_disj;
  logic [CNT_W-1:0]  r_drop;

  logic [23:0]       w_ka;
  logic [23:0]       w_kb;
  logic              w_oavail;
  logic              w_keep_a;
  logic              w_keep_b;
  logic              w_a_rdy;
  logic              w_b_rdy;
  logic              w_emit;
  logic [GENE_W-1:0] w_p1;
  logic [GENE_W-1:0] w_p2;
  logic              w_inc_m;
  logic              w_inc_d;
  logic              w_inc_x;
  logic              w_done;

  function automatic logic [CNT_W-1:0] f_inc(
    input logic [CNT_W-1:0] c
  );
    f_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  // node genes align on type+node id only
  assign w_ka = a_gene[55] ? a_gene[55:32]
                           : {a_gene[55:40], 8'h00};
  assign w_kb = b_gene[55] ? b_gene[55:32]
                           : {b_gene[55:40], 8'h00};

  assign w_oavail = !r_wr || out_ready;
  assign w_keep_a = (r_fit != 2'b10);
  assign w_keep_b = (r_fit != 2'b01);

  always_comb begin
    w_next  = r_state;
    w_a_rdy = 1'b0;
    w_b_rdy = 1'b0;
    w_emit  = 1'b0;
    w_p1    = '0;
    w_p2    = '0;
    w_inc_m = 1'b0;
    w_inc_d = 1'b0;
    w_inc_x = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = MERGE;
      end
      MERGE: begin
        if (a_valid && b_valid) begin
          if (w_ka == w_kb) begin
            if (w_oavail) begin
              w_a_rdy = 1'b1;
              w_b_rdy = 1'b1;
              w_emit  = 1'b1;
              w_p1    = a_gene;
              w_p2    = b_gene;
              w_inc_m = 1'b1;
              if (a_last && b_last) w_next = FLUSH;
              else if (a_last)      w_next = DRAIN_B;
              else if (b_last)      w_next = DRAIN_A;
            end
          end else if (w_ka < w_kb) begin
            if (!w_keep_a || w_oavail) begin
              w_a_rdy = 1'b1;
              w_emit  = w_keep_a;
              w_p1    = a_gene;
              w_p2    = a_gene;
              w_inc_d = w_keep_a;
              w_inc_x = !w_keep_a;
              if (a_last) w_next = DRAIN_B;
            end
          end else begin
            if (!w_keep_b || w_oavail) begin
              w_b_rdy = 1'b1;
              w_emit  = w_keep_b;
              w_p1    = b_gene;
              w_p2    = b_gene;
              w_inc_d = w_keep_b;
              w_inc_x = !w_keep_b;
              if (b_last) w_next = DRAIN_A;
            end
          end
        end
      end
      DRAIN_A: begin
        if (a_valid && (!w_keep_a || w_oavail)) begin
          w_a_rdy = 1'b1;
          w_emit  = w_keep_a;
          w_p1    = a_gene;
          w_p2    = a_gene;
          w_inc_d = w_keep_a;
          w_inc_x = !w_keep_a;
          if (a_last) w_next = FLUSH;
        end
      end
      DRAIN_B: begin
        if (b_valid && (!w_keep_b || w_oavail)) begin
          w_b_rdy = 1'b1;
          w_emit  = w_keep_b;
          w_p1    = b_gene;
          w_p2    = b_gene;
          w_inc_d = w_keep_b;
          w_inc_x = !w_keep_b;
          if (b_last) w_next = FLUSH;
        end
      end
      FLUSH: begin
        if (w_oavail) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_fit   <= 2'b00;
      r_p1    <= '0;
      r_p2    <= '0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_match <= '0;
      r_disj  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (r_state == IDLE && start) begin
        r_fit   <= fit_sel;
        r_match <= '0;
        r_disj  <= '0;
        r_drop  <= '0;
      end else begin
        if (w_inc_m) r_match <= f_inc(r_match);
        if (w_inc_d) r_disj  <= f_inc(r_disj);
        if (w_inc_x) r_drop  <= f_inc(r_drop);
      end
      if (w_oavail) begin
        r_wr <= w_emit;
        if (w_emit) begin
          r_p1 <= w_p1;
          r_p2 <= w_p2;
        end
      end
    end
  end

  assign a_ready      = w_a_rdy;
  assign b_ready      = w_b_rdy;
  assign parent1      = r_p1;
  assign parent2      = r_p2;
  assign wr_en        = r_wr;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign match_cnt    = r_match;
  assign disjoint_cnt = r_disj;
  assign drop_cnt     = r_drop;

endmodule
